// File: rtl/i2c_slv_regctl.sv
// i2c_slv_regctl: register-access sequencer behind i2c_slv.
// A slave-write transaction is an 8-bit register pointer followed by data
// bytes, each written to the register bank with pointer auto-increment.
// A slave-read transaction prefetches the register at the pointer into a
// one-byte transmit buffer. rx_full/tx_empty hold i2c_slv in clock stretch
// while a bank access is outstanding.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   sr_aas, sr_abgc, sr_srw        slave status from i2c_slv
//   rx_wr, rx_dat, rx_full         receive byte path / backpressure
//   tx_rd, tx_dat, tx_empty        transmit byte path / backpressure
//   reg_addr, reg_wr, reg_wdata,   register bank write handshake
//   reg_ack
//   reg_rd, reg_rdata, reg_rvalid  register bank read handshake
//   busy, err_to, err_clr          status, sticky timeout flag and clear
module i2c_slv_regctl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sr_aas,
  input  logic              sr_abgc,
  input  logic              sr_srw,
  input  logic              rx_wr,
  input  logic [7:0]        rx_dat,
  output logic              rx_full,
  input  logic              tx_rd,
  output logic [7:0]        tx_dat,
  output logic              tx_empty,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  input  logic              reg_ack,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_rvalid,
  output logic              busy,
  output logic              err_to,
  input  logic              err_clr
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PTR    = 3'd1;
  localparam logic [2:0] ST_WDATA  = 3'd2;
  localparam logic [2:0] ST_WWAIT  = 3'd3;
  localparam logic [2:0] ST_RFETCH = 3'd4;
  localparam logic [2:0] ST_RWAIT  = 3'd5;
  localparam logic [2:0] ST_RREADY = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              aas_q;
  logic              abort_q;
  logic [15:0]       cnt;
  logic              aas_rise;
  logic              aas_fall;
  logic              expire;
  logic              aborted;

  assign aas_rise = sr_aas & ~aas_q;
  assign aas_fall = aas_q & ~sr_aas;
  // cnt is cleared on entry to a wait state, so the request is held for
  // exactly TIMEOUT cycles before expiry.
  assign expire   = (cnt == 16'(TIMEOUT - 1));
  // An abort seen while a bank access is in flight is remembered so the
  // access can finish before returning to IDLE.
  assign aborted  = abort_q | aas_fall;
  assign reg_addr = ptr;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      aas_q     <= 1'b0;
      abort_q   <= 1'b0;
      cnt       <= '0;
      rx_full   <= 1'b0;
      tx_empty  <= 1'b1;
      tx_dat    <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_wdata <= '0;
      err_to    <= 1'b0;
    end else begin
      aas_q <= sr_aas;
      if (err_clr) err_to <= 1'b0;

      case (state)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (aas_rise && !sr_abgc) state <= sr_srw ? ST_RFETCH : ST_PTR;
        end

        ST_PTR: begin
          if (!sr_aas) begin
            state    <= ST_IDLE;
            tx_empty <= 1'b1;
          end else if (rx_wr) begin
            ptr   <= ADDR_W'(rx_dat);
            state <= ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (!sr_aas) begin
            state    <= ST_IDLE;
            tx_empty <= 1'b1;
          end else if (rx_wr) begin
            reg_wdata <= rx_dat;
            reg_wr    <= 1'b1;
            rx_full   <= 1'b1;
            cnt       <= '0;
            state     <= ST_WWAIT;
          end
        end

        ST_WWAIT: begin
          if (aas_fall) abort_q <= 1'b1;
          if (reg_ack || expire) begin
            reg_wr  <= 1'b0;
            rx_full <= 1'b0;
            ptr     <= ptr + ADDR_W'(1);
            abort_q <= 1'b0;
            if (!reg_ack) err_to <= 1'b1;
            state   <= aborted ? ST_IDLE : ST_WDATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_RFETCH: begin
          if (!sr_aas) begin
            state    <= ST_IDLE;
            tx_empty <= 1'b1;
          end else begin
            reg_rd <= 1'b1;
            cnt    <= '0;
            state  <= ST_RWAIT;
          end
        end

        ST_RWAIT: begin
          if (aas_fall) abort_q <= 1'b1;
          if (reg_rvalid || expire) begin
            reg_rd  <= 1'b0;
            abort_q <= 1'b0;
            if (!reg_rvalid) err_to <= 1'b1;
            if (aborted) begin
              // fetched byte is dropped; the pointer still addresses it
              state <= ST_IDLE;
            end else begin
              tx_dat   <= reg_rvalid ? reg_rdata : 8'hFF;
              tx_empty <= 1'b0;
              state    <= ST_RREADY;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_RREADY: begin
          if (!sr_aas) begin
            state    <= ST_IDLE;
            tx_empty <= 1'b1;
          end else if (tx_rd) begin
            tx_empty <= 1'b1;
            ptr      <= ptr + ADDR_W'(1);
            state    <= ST_RFETCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slv_regctl.sv
// Self-checking bench for i2c_slv_regctl: directed scenarios followed by
// randomized write/read transactions checked against a pointer/bank model.
module tb_i2c_slv_regctl;

  localparam int TO = 4;

  logic       clk;
  logic       rstn;
  logic       sr_aas, sr_abgc, sr_srw;
  logic       rx_wr;
  logic [7:0] rx_dat;
  logic       rx_full;
  logic       tx_rd;
  logic [7:0] tx_dat;
  logic       tx_empty;
  logic [7:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_rvalid;
  logic       busy;
  logic       err_to;
  logic       err_clr;

  i2c_slv_regctl #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sr_aas     (sr_aas),
    .sr_abgc    (sr_abgc),
    .sr_srw     (sr_srw),
    .rx_wr      (rx_wr),
    .rx_dat     (rx_dat),
    .rx_full    (rx_full),
    .tx_rd      (tx_rd),
    .tx_dat     (tx_dat),
    .tx_empty   (tx_empty),
    .reg_addr   (reg_addr),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_ack    (reg_ack),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .busy       (busy),
    .err_to     (err_to),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: register bank contents, expected pointer, error flag
  logic [7:0] bank [256];
  int         exp_ptr;
  logic       exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic rw);
    sr_srw = rw;
    sr_aas = 1'b1;
    tick();
    chk("busy_start", busy, 1);
  endtask

  task automatic stop_txn();
    sr_aas = 1'b0;
    tick();
    chk("idle_stop", busy, 0);
    chk("txe_stop", tx_empty, 1);
    chk("ptr_stop", reg_addr, exp_ptr);
  endtask

  task automatic send_ptr(input logic [7:0] p);
    rx_dat = p;
    rx_wr  = 1'b1;
    tick();
    rx_wr  = 1'b0;
    exp_ptr = p;
    chk("ptr_load", reg_addr, exp_ptr);
    chk("rxf_ptr", rx_full, 0);
  endtask

  // lat < 0: bank never acknowledges; abort: sr_aas dropped during the wait
  task automatic send_data(input logic [7:0] d, input int lat, input bit abort);
    int n;
    rx_dat = d;
    rx_wr  = 1'b1;
    tick();
    rx_wr  = 1'b0;
    chk("wr_req", reg_wr, 1);
    chk("rxf_set", rx_full, 1);
    chk("waddr", reg_addr, exp_ptr);
    chk("wdata", reg_wdata, d);
    if (abort) sr_aas = 1'b0;
    if (lat >= 0) begin
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("wr_hold", reg_wr, 1);
        chk("rxf_hold", rx_full, 1);
      end
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      bank[exp_ptr] = d;
    end else begin
      n = 0;
      while (reg_wr === 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("wr_to_cycles", n, TO);
      exp_err = 1'b1;
    end
    exp_ptr = (exp_ptr + 1) % 256;
    chk("wr_done", reg_wr, 0);
    chk("rxf_clr", rx_full, 0);
    chk("err_wr", err_to, exp_err);
    chk("ptr_wr", reg_addr, exp_ptr);
    if (abort) chk("wr_abort_idle", busy, 0);
  endtask

  // lat < 0: bank never returns data; clr_hold keeps err_clr high throughout
  task automatic fetch_byte(input int lat, input bit clr_hold);
    int n;
    logic [7:0] exp_tx;
    n = 0;
    while (reg_rd !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    chk("rd_lat", n, 1);
    chk("raddr", reg_addr, exp_ptr);
    chk("txe_fetch", tx_empty, 1);
    if (lat >= 0) begin
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("rd_hold", reg_rd, 1);
      end
      reg_rvalid = 1'b1;
      reg_rdata  = bank[exp_ptr];
      exp_tx     = bank[exp_ptr];
      tick();
      reg_rvalid = 1'b0;
      reg_rdata  = 8'($urandom);
    end else begin
      if (clr_hold) err_clr = 1'b1;
      n = 0;
      while (reg_rd === 1'b1 && n < 20) begin
        tick();
        n++;
      end
      err_clr = 1'b0;
      chk("rd_to_cycles", n, TO);
      exp_tx  = 8'hFF;
      exp_err = 1'b1;
    end
    chk("rd_done", reg_rd, 0);
    chk("txe_loaded", tx_empty, 0);
    chk("tx_dat", tx_dat, exp_tx);
    chk("err_rd", err_to, exp_err);
    chk("ptr_rd", reg_addr, exp_ptr);
  endtask

  task automatic consume();
    tx_rd = 1'b1;
    tick();
    tx_rd = 1'b0;
    exp_ptr = (exp_ptr + 1) % 256;
    chk("txe_consumed", tx_empty, 1);
    chk("ptr_consumed", reg_addr, exp_ptr);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", err_to, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rxf"}, rx_full, 0);
    chk({tag, "_txe"}, tx_empty, 1);
    chk({tag, "_txd"}, tx_dat, 8'h00);
    chk({tag, "_wr"}, reg_wr, 0);
    chk({tag, "_rd"}, reg_rd, 0);
    chk({tag, "_wdat"}, reg_wdata, 8'h00);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_to, 0);
    chk({tag, "_addr"}, reg_addr, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    sr_aas = 1'b0; sr_abgc = 1'b0; sr_srw = 1'b0;
    rx_wr = 1'b0; rx_dat = '0; tx_rd = 1'b0;
    reg_ack = 1'b0; reg_rdata = '0; reg_rvalid = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    exp_ptr = 0;
    exp_err = 1'b0;
    #12;
    chk_reset_outputs("rst");
    tick();
    rstn = 1'b1;
    tick();
    chk_reset_outputs("post_rst");

    // general call is ignored
    sr_abgc = 1'b1;
    sr_aas  = 1'b1;
    tick();
    tick();
    chk("gc_ignored", busy, 0);
    sr_aas  = 1'b0;
    tick();
    sr_abgc = 1'b0;

    // pointer 0x10, two data bytes
    start_txn(1'b0);
    send_ptr(8'h10);
    send_data(8'hA1, 2, 1'b0);
    send_data(8'hB2, 2, 1'b0);
    chk("ptr_after_write", reg_addr, 8'h12);
    stop_txn();

    // pointer write, repeated START, read
    start_txn(1'b0);
    send_ptr(8'h20);
    stop_txn();
    bank[8'h20] = 8'h5A;
    bank[8'h21] = 8'h5B;
    start_txn(1'b1);
    fetch_byte(1, 1'b0);
    consume();
    fetch_byte(0, 1'b0);
    chk("ptr_unsent", reg_addr, 8'h21);
    consume();
    stop_txn();

    // pointer wrap, ack arriving on the expiry cycle
    start_txn(1'b0);
    send_ptr(8'hFF);
    send_data(8'h33, TO - 1, 1'b0);
    send_data(8'h44, 0, 1'b0);
    chk("wrap_ptr", reg_addr, 8'h01);
    stop_txn();

    // read timeout, then clear
    start_txn(1'b1);
    fetch_byte(-1, 1'b0);
    clear_err();
    stop_txn();
    // stop with unsent prefetched byte, next read refetches it
    start_txn(1'b1);
    fetch_byte(2, 1'b0);
    stop_txn();
    start_txn(1'b1);
    fetch_byte(0, 1'b0);
    stop_txn();

    // write abort mid-wait completes the write first
    start_txn(1'b0);
    send_ptr(8'h40);
    send_data(8'h77, 1, 1'b1);

    // reset during a pending write
    start_txn(1'b0);
    send_ptr(8'h50);
    rx_dat = 8'h99;
    rx_wr  = 1'b1;
    tick();
    rx_wr  = 1'b0;
    chk("pre_rst_wr", reg_wr, 1);
    #2 rstn = 1'b0;
    sr_aas = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    rstn = 1'b1;
    exp_ptr = 0;
    exp_err = 1'b0;
    tick();

    // randomized transactions
    for (int it = 0; it < 60; it++) begin
      int op;
      op = int'($urandom_range(0, 4));
      if (op <= 1) begin
        int nb;
        logic [7:0] p;
        start_txn(1'b0);
        p = ($urandom_range(0, 3) == 0) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom);
        send_ptr(p);
        nb = int'($urandom_range(1, 4));
        for (int b = 0; b < nb; b++) begin
          int lat;
          bit ab;
          lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
          ab  = (b == nb - 1) && ($urandom_range(0, 3) == 0);
          send_data(8'($urandom), lat, ab);
          if (ab) break;
        end
        if (sr_aas) stop_txn();
      end else if (op <= 3) begin
        int nb;
        start_txn(1'b1);
        nb = int'($urandom_range(1, 3));
        for (int b = 0; b < nb; b++) begin
          int lat;
          lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
          fetch_byte(lat, 1'($urandom_range(0, 1)));
          if (b < nb - 1 || $urandom_range(0, 1) == 1) consume();
        end
        stop_txn();
      end else begin
        clear_err();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
